spi_slave_burst_sched: RTL and testbench
========================================

# spi_slave_burst_sched

Burst scheduler between the SPI slave command path and the AXI plug's address channels. It accepts one transfer command at a time: start address, length in data beats, and direction. It splits the command into legal AXI INCR bursts of at most MAX_BURST beats, none crossing a 4 KB boundary, and issues them one by one over a valid/ready burst interface. Runs entirely in the AXI clock domain, after the address/CS synchronizer.

## Interface
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 64, beat width in bits; BYTES = AXI_DATA_WIDTH/8 (power of two, 4..128)
- MAX_BURST, 16, maximum beats per burst (power of two, 1..256)

Ports:
- axi_aclk  in  1  clock; one clock, all logic on rising edge
- axi_aresetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  AXI_ADDR_WIDTH  start byte address; low log2(BYTES) bits ignored and forced to 0
- cmd_beats  in  16  transfer length in beats; 0 is legal (no-op)
- cmd_rd_wr  in  1  1 = read, 0 = write
- abort  in  1  synchronized CS deassertion; stops scheduling further bursts
- burst_valid  out  1  burst descriptor valid
- burst_ready  in  1  burst consumed when burst_valid & burst_ready
- burst_addr  out  AXI_ADDR_WIDTH  burst start address (beat aligned)
- burst_len  out  8  AXI len = beats-1
- burst_rd_wr  out  1  direction, constant for the whole command
- burst_last  out  1  high on the final burst of the command
- done  out  1  one-cycle pulse: command finished normally or aborted
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, CALC, ISSUE.
- IDLE: cmd_ready=1. On handshake, latch addr (aligned), beats into rem, and rd_wr.
  - beats != 0 -> CALC.
  - beats == 0 -> stay IDLE, pulse done next cycle, no burst issued.
- CALC: compute and register the burst fields.
  - to_bound = (4096 - addr[11:0]) / BYTES
  - n = min(rem, MAX_BURST, to_bound)
  - burst_len = n-1; burst_last = (rem == n)
  - Then -> ISSUE.
- ISSUE: burst_valid=1; addr/len/rd_wr/last held stable until handshake.
  - On handshake: addr += n*BYTES (mod 2^AXI_ADDR_WIDTH), rem -= n.
  - If rem becomes 0 or abort is latched: -> IDLE with done pulse; else -> CALC.
- abort behaviour:
  - In CALC: -> IDLE immediately, done pulse, no further burst.
  - In ISSUE: latched into abort_q. The current descriptor is never withdrawn (AXI valid rule). After its handshake -> IDLE, done.
  - In IDLE: ignored; a command accepted while abort=1 is dropped: go to IDLE, done pulse.
- burst_last: a burst issued before an abort keeps the value computed in CALC. An abort does not retroactively set it.
- Width rules:
  - n is at most 256, so burst_len fits in 8 bits.
  - rem is 16-bit unsigned and never underflows, because n ≤ rem.
  - to_bound is at least 1 because addr is beat aligned.

## Timing
- Reset values: cmd_ready=1 (IDLE), burst_valid=0, burst_addr=0, burst_len=0, burst_rd_wr=0, burst_last=0, done=0, busy=0. abort_q, rem and addr are cleared.
- Command handshake at edge 0 -> CALC after edge 0 -> burst_valid high after edge 1. Latency is 2 cycles.
- Burst handshake at edge k -> next burst_valid after edge k+1. There is exactly one bubble cycle (CALC) between bursts.
- Final handshake at edge k -> done=1 and cmd_ready=1 during cycle k+1. A new command can be accepted at edge k+1.
- burst_valid may rise without waiting for burst_ready. Once high, it stays high until the handshake.
- done is never asserted together with burst_valid.
- Asynchronous reset mid-command: all outputs return to reset values immediately. There is no partial-command memory.

## Test plan
- Multi-burst split: BYTES=8, cmd addr 0x1000, beats 40, write. Required: bursts (0x1000, len 15, last 0), (0x1080, len 15, last 0), (0x1100, len 7, last 1); done one cycle after the third handshake; burst_rd_wr=0 throughout.
- 4 KB split: addr 0x0FF0, beats 4, read. Required: (0x0FF0, len 1), (0x1000, len 1, last 1). Also addr 0x0FFB, beats 1: address aligned to 0x0FF8, single burst with len 0.
- Backpressure: burst_ready held 0 for 5 cycles during the second burst of a 40-beat command. Required: burst_valid, addr, len and last stable all 5 cycles; total bursts still 3.
- Abort: assert abort during CALC before burst 2 -> only burst 1 issued, done pulses, back to IDLE. Separately, assert abort in ISSUE of burst 1 -> burst 1 still handshakes unchanged, no burst 2.
- Zero length and back-to-back: beats 0 -> no burst_valid, done after 1 cycle. Then a second command accepted on the done cycle -> first burst_valid 2 cycles later.
- Reset mid-operation: deassert axi_aresetn while burst_valid=1 -> burst_valid, busy and done go 0 without a clock edge. After release, a new command works normally.

Source files
------------

// File: rtl/spi_slave_burst_sched_if.sv
// Command and burst-descriptor bundle between the SPI command path and the
// AXI address-channel burst scheduler.
interface spi_slave_burst_sched_if #(
  parameter int AXI_ADDR_WIDTH = 32
) ();
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [AXI_ADDR_WIDTH-1:0] cmd_addr;
  logic [15:0]               cmd_beats;
  logic                      cmd_rd_wr;
  logic                      abort;
  logic                      burst_valid;
  logic                      burst_ready;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr;
  logic [7:0]                burst_len;
  logic                      burst_rd_wr;
  logic                      burst_last;
  logic                      done;
  logic                      busy;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_beats, cmd_rd_wr, abort, burst_ready,
    output cmd_ready, burst_valid, burst_addr, burst_len, burst_rd_wr,
           burst_last, done, busy
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_beats, cmd_rd_wr, abort, burst_ready,
    input  cmd_ready, burst_valid, burst_addr, burst_len, burst_rd_wr,
           burst_last, done, busy
  );
endinterface

// File: rtl/spi_slave_burst_sched.sv
// Splits one SPI transfer command into AXI INCR bursts of at most MAX_BURST
// beats that never cross a 4 KB page, issued one at a time over valid/ready.
module spi_slave_burst_sched #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MAX_BURST      = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_aresetn,
  spi_slave_burst_sched_if.slave bus
);

  localparam int BYTES      = AXI_DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = AXI_ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_nx_s;
  logic                      done_nx_s;

  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [15:0]               rem_r;
  logic                      rd_wr_r;
  logic [8:0]                n_r;
  logic                      abort_q_r;

  logic                      cmd_ready_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      burst_valid_r;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr_r;
  logic [7:0]                burst_len_r;
  logic                      burst_rd_wr_r;
  logic                      burst_last_r;

  logic                      cmd_hs_s;
  logic                      burst_hs_s;
  logic [12:0]               bound_bytes_s;
  logic [12:0]               to_bound_s;
  logic                      rem_lt_max_s;
  logic [8:0]                cap_s;
  logic [8:0]                n_s;
  logic                      last_s;
  logic [AXI_ADDR_WIDTH-1:0] addr_step_s;
  logic                      rem_spent_s;

  assign cmd_hs_s   = bus.cmd_valid & cmd_ready_r;
  assign burst_hs_s = burst_valid_r & bus.burst_ready;

  // Beats left before the 4 KB page ends; never zero since addr_r is beat aligned.
  assign bound_bytes_s = 13'd4096 - {1'b0, addr_r[11:0]};
  assign to_bound_s    = bound_bytes_s >> BYTE_SHIFT;
  assign rem_lt_max_s  = (rem_r < 16'(MAX_BURST));
  assign cap_s         = rem_lt_max_s ? rem_r[8:0] : 9'(MAX_BURST);
  assign n_s           = (to_bound_s < {4'd0, cap_s}) ? to_bound_s[8:0] : cap_s;
  assign last_s        = ({7'd0, n_s} == rem_r);

  assign addr_step_s = AXI_ADDR_WIDTH'(n_r) << BYTE_SHIFT;
  assign rem_spent_s = (rem_r == {7'd0, n_r});

  // Next-state and done-pulse decision
  always_comb begin
    state_nx_s = state_r;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_hs_s) begin
          if (bus.abort || (bus.cmd_beats == 16'd0)) begin
            done_nx_s = 1'b1;
          end else begin
            state_nx_s = CALC;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      CALC: begin
        if (bus.abort) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = ISSUE;
        end
      end
      ISSUE: begin
        // An issued descriptor is never withdrawn; abort only takes effect after its handshake.
        if (burst_hs_s) begin
          if (rem_spent_s || abort_q_r || bus.abort) begin
            state_nx_s = IDLE;
            done_nx_s  = 1'b1;
          end else begin
            state_nx_s = CALC;
          end
        end else begin
          state_nx_s = ISSUE;
        end
      end
      default: begin
        state_nx_s = IDLE;
        done_nx_s  = 1'b0;
      end
    endcase
  end

  // State register and status outputs registered from the next state
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_r       <= IDLE;
      cmd_ready_r   <= 1'b1;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      burst_valid_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cmd_ready_r   <= (state_nx_s == IDLE);
      busy_r        <= (state_nx_s != IDLE);
      done_r        <= done_nx_s;
      burst_valid_r <= (state_nx_s == ISSUE);
    end
  end

  // Abort seen while a descriptor is outstanding, held until that descriptor retires
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      abort_q_r <= 1'b0;
    end else if ((state_r == ISSUE) && (state_nx_s == ISSUE)) begin
      abort_q_r <= abort_q_r | bus.abort;
    end else begin
      abort_q_r <= 1'b0;
    end
  end

  // Command progress: running address, remaining beats and direction
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      addr_r  <= '0;
      rem_r   <= 16'd0;
      rd_wr_r <= 1'b0;
      n_r     <= 9'd0;
    end else if (cmd_hs_s) begin
      addr_r  <= bus.cmd_addr & ~BEAT_MASK;
      rem_r   <= bus.cmd_beats;
      rd_wr_r <= bus.cmd_rd_wr;
    end else if (state_r == CALC) begin
      n_r     <= n_s;
    end else if (burst_hs_s) begin
      addr_r  <= addr_r + addr_step_s;
      rem_r   <= rem_r - {7'd0, n_r};
    end
  end

  // Burst descriptor fields, loaded only when a burst is about to be offered
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      burst_addr_r  <= '0;
      burst_len_r   <= 8'd0;
      burst_rd_wr_r <= 1'b0;
      burst_last_r  <= 1'b0;
    end else if ((state_r == CALC) && (state_nx_s == ISSUE)) begin
      burst_addr_r  <= addr_r;
      burst_len_r   <= 8'(n_s - 9'd1);
      burst_rd_wr_r <= rd_wr_r;
      burst_last_r  <= last_s;
    end
  end

  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.burst_valid = burst_valid_r;
  assign bus.burst_addr  = burst_addr_r;
  assign bus.burst_len   = burst_len_r;
  assign bus.burst_rd_wr = burst_rd_wr_r;
  assign bus.burst_last  = burst_last_r;

endmodule

// File: tb/tb_spi_slave_burst_sched.sv
// Bench for spi_slave_burst_sched: table vectors, abort/reset sequences and
// random commands checked against a burst-list reference model.
module tb_spi_slave_burst_sched;

  localparam int AW    = 32;
  localparam int BYTES = 8;
  localparam int MAXB  = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_slave_burst_sched_if #(.AXI_ADDR_WIDTH(AW)) bus ();

  spi_slave_burst_sched #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(64),
    .MAX_BURST(MAXB)
  ) dut (
    .axi_aclk(clk),
    .axi_aresetn(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        last;
  } burst_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] beats;
    logic        rd;
    int          hold_idx;
    int          hold_cyc;
    int          exp_n;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] al;
    logic [7:0]  ll;
  } vec_t;

  burst_t exp_q[$];
  burst_t obs_q[$];
  vec_t   tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Burst list from the splitting rules: page limit, MAX_BURST cap, remaining beats.
  function automatic void build_model(input logic [31:0] a_in, input logic [15:0] beats);
    logic [31:0] a;
    int rem, page_n, n;
    burst_t e;
    exp_q.delete();
    a   = a_in & ~(32'(BYTES - 1));
    rem = int'(beats);
    while (rem > 0) begin
      page_n = (4096 - int'(a[11:0])) / BYTES;
      n = rem;
      if (n > MAXB)   n = MAXB;
      if (n > page_n) n = page_n;
      e.addr = a;
      e.len  = 8'(n - 1);
      e.last = (n == rem);
      exp_q.push_back(e);
      a   = a + 32'(n * BYTES);
      rem = rem - n;
    end
  endfunction

  task automatic check_burst(input string tag, input burst_t e, input logic rd);
    chk({tag, "_valid"}, bus.burst_valid, 1'b1);
    chk({tag, "_addr"},  bus.burst_addr,  e.addr);
    chk({tag, "_len"},   bus.burst_len,   e.len);
    chk({tag, "_last"},  bus.burst_last,  e.last);
    chk({tag, "_rd_wr"}, bus.burst_rd_wr, rd);
    chk({tag, "_done"},  bus.done,        1'b0);
  endtask

  task automatic start_cmd(input logic [31:0] addr, input logic [15:0] beats, input logic rd);
    chk("cmd_ready_before_cmd", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = addr;
    bus.cmd_beats = beats;
    bus.cmd_rd_wr = rd;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] addr, input logic [15:0] beats, input logic rd,
                         input int bp_pct, input int hold_idx, input int hold_cyc);
    int nb;
    int hold;
    burst_t o;
    build_model(addr, beats);
    obs_q.delete();
    nb = exp_q.size();
    start_cmd(addr, beats, rd);
    if (nb == 0) begin
      chk("zero_done",  bus.done,        1'b1);
      chk("zero_valid", bus.burst_valid, 1'b0);
      chk("zero_busy",  bus.busy,        1'b0);
      chk("zero_ready", bus.cmd_ready,   1'b1);
    end else begin
      chk("calc_valid", bus.burst_valid, 1'b0);
      chk("calc_busy",  bus.busy,        1'b1);
      chk("calc_done",  bus.done,        1'b0);
      step();
      for (int b = 0; b < nb; b++) begin
        check_burst("issue", exp_q[b], rd);
        hold = (b == hold_idx) ? hold_cyc :
               ((int'($urandom_range(0, 99)) < bp_pct) ? int'($urandom_range(1, 3)) : 0);
        for (int w = 0; w < hold; w++) begin
          step();
          check_burst("held", exp_q[b], rd);
        end
        o.addr = bus.burst_addr;
        o.len  = bus.burst_len;
        o.last = bus.burst_last;
        obs_q.push_back(o);
        bus.burst_ready = 1'b1;
        step();
        bus.burst_ready = 1'b0;
        if (b == nb - 1) begin
          chk("end_done",  bus.done,        1'b1);
          chk("end_valid", bus.burst_valid, 1'b0);
          chk("end_ready", bus.cmd_ready,   1'b1);
          chk("end_busy",  bus.busy,        1'b0);
        end else begin
          chk("bubble_valid", bus.burst_valid, 1'b0);
          chk("bubble_busy",  bus.busy,        1'b1);
          chk("bubble_done",  bus.done,        1'b0);
          step();
        end
      end
    end
  endtask

  initial begin
    burst_t      e;
    logic [31:0] ra;
    logic [15:0] rb;
    int          r;

    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = 32'd0;
    bus.cmd_beats   = 16'd0;
    bus.cmd_rd_wr   = 1'b0;
    bus.abort       = 1'b0;
    bus.burst_ready = 1'b0;

    tbl[0] = '{32'h0000_1000, 16'd40,  1'b0,  1, 5,  3, 32'h0000_1000, 8'd15, 32'h0000_1100, 8'd7};
    tbl[1] = '{32'h0000_0FF0, 16'd4,   1'b1, -1, 0,  2, 32'h0000_0FF0, 8'd1,  32'h0000_1000, 8'd1};
    tbl[2] = '{32'h0000_0FFB, 16'd1,   1'b1, -1, 0,  1, 32'h0000_0FF8, 8'd0,  32'h0000_0FF8, 8'd0};
    tbl[3] = '{32'h0000_1234, 16'd0,   1'b0, -1, 0,  0, 32'h0,         8'd0,  32'h0,         8'd0};
    tbl[4] = '{32'h0000_0040, 16'd5,   1'b1, -1, 0,  1, 32'h0000_0040, 8'd4,  32'h0000_0040, 8'd4};
    tbl[5] = '{32'h0000_0000, 16'd17,  1'b0, -1, 0,  2, 32'h0000_0000, 8'd15, 32'h0000_0080, 8'd0};
    tbl[6] = '{32'hFFFF_FFF8, 16'd3,   1'b1, -1, 0,  2, 32'hFFFF_FFF8, 8'd0,  32'h0000_0000, 8'd1};
    tbl[7] = '{32'h0000_2F40, 16'd300, 1'b1, -1, 0, 20, 32'h0000_2F40, 8'd15, 32'h0000_3880, 8'd3};

    @(posedge clk);
    #1;
    chk("rst_cmd_ready",   bus.cmd_ready,   1'b1);
    chk("rst_burst_valid", bus.burst_valid, 1'b0);
    chk("rst_burst_addr",  bus.burst_addr,  32'd0);
    chk("rst_burst_len",   bus.burst_len,   8'd0);
    chk("rst_burst_rd_wr", bus.burst_rd_wr, 1'b0);
    chk("rst_burst_last",  bus.burst_last,  1'b0);
    chk("rst_done",        bus.done,        1'b0);
    chk("rst_busy",        bus.busy,        1'b0);
    #3 rst_n = 1'b1;
    step();

    // Table vectors; entry 3 (zero beats) is followed directly by entry 4 on its done cycle.
    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].addr, tbl[i].beats, tbl[i].rd, 0, tbl[i].hold_idx, tbl[i].hold_cyc);
      chk("tbl_burst_count", obs_q.size(), tbl[i].exp_n);
      if (tbl[i].exp_n > 0) begin
        chk("tbl_first_addr", obs_q[0].addr, tbl[i].a0);
        chk("tbl_first_len",  obs_q[0].len,  tbl[i].l0);
        chk("tbl_final_addr", obs_q[obs_q.size()-1].addr, tbl[i].al);
        chk("tbl_final_len",  obs_q[obs_q.size()-1].len,  tbl[i].ll);
        chk("tbl_final_last", obs_q[obs_q.size()-1].last, 1'b1);
      end
    end

    // Abort in CALC ahead of the second burst.
    e = '{32'h0000_1000, 8'd15, 1'b0};
    start_cmd(32'h0000_1000, 16'd40, 1'b0);
    step();
    check_burst("abc_b1", e, 1'b0);
    bus.burst_ready = 1'b1;
    step();
    bus.burst_ready = 1'b0;
    chk("abc_calc_valid", bus.burst_valid, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abc_done",  bus.done,        1'b1);
    chk("abc_valid", bus.burst_valid, 1'b0);
    chk("abc_ready", bus.cmd_ready,   1'b1);
    chk("abc_busy",  bus.busy,        1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abc_quiet_valid", bus.burst_valid, 1'b0);
      chk("abc_quiet_done",  bus.done,        1'b0);
    end

    // Abort while burst 1 is offered: it stays, unchanged, until taken.
    start_cmd(32'h0000_1000, 16'd40, 1'b0);
    step();
    check_burst("abi_pre", e, 1'b0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_burst("abi_held", e, 1'b0);
    step();
    check_burst("abi_held2", e, 1'b0);
    bus.burst_ready = 1'b1;
    step();
    bus.burst_ready = 1'b0;
    chk("abi_done",  bus.done,        1'b1);
    chk("abi_valid", bus.burst_valid, 1'b0);
    chk("abi_ready", bus.cmd_ready,   1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abi_quiet_valid", bus.burst_valid, 1'b0);
    end

    // Abort in IDLE: ignored alone, drops a command accepted with it.
    bus.abort = 1'b1;
    step();
    chk("abidle_done", bus.done, 1'b0);
    chk("abidle_busy", bus.busy, 1'b0);
    start_cmd(32'h0000_2000, 16'd8, 1'b1);
    bus.abort = 1'b0;
    chk("abdrop_done",  bus.done,        1'b1);
    chk("abdrop_busy",  bus.busy,        1'b0);
    chk("abdrop_valid", bus.burst_valid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abdrop_quiet_valid", bus.burst_valid, 1'b0);
    end

    // Asynchronous reset while a burst is offered.
    start_cmd(32'h0000_1000, 16'd40, 1'b0);
    step();
    chk("rmid_valid_before", bus.burst_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rmid_valid", bus.burst_valid, 1'b0);
    chk("rmid_busy",  bus.busy,        1'b0);
    chk("rmid_done",  bus.done,        1'b0);
    chk("rmid_ready", bus.cmd_ready,   1'b1);
    chk("rmid_addr",  bus.burst_addr,  32'd0);
    chk("rmid_len",   bus.burst_len,   8'd0);
    #3 rst_n = 1'b1;
    step();
    chk("rmid_after_valid", bus.burst_valid, 1'b0);
    chk("rmid_after_busy",  bus.busy,        1'b0);
    run_cmd(32'h0000_0FF0, 16'd4, 1'b1, 0, -1, 0);
    chk("rmid_rerun_count", obs_q.size(), 2);

    // Random commands with random backpressure against the reference model.
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'hFFF - 12'($urandom_range(0, 300));
      r  = int'($urandom_range(0, 9));
      rb = (r == 0) ? 16'd0 :
           (r < 7)  ? 16'($urandom_range(1, 50)) : 16'($urandom_range(51, 400));
      run_cmd(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 60)), -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
